// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the five-stage RISC-V core.
// Used by fetch_stage and ifid_reg.
package rv_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and flush-to-bubble controls.
// Reset and flush both leave the register holding a bubble.
module ifid_reg
  import rv_pipe_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc    <= '0;
      inst  <= INST_W'(NOP_INST);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      inst  <= inst_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RUN/FAULT FSM, IF/ID register, perf counters.
// Counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [INST_W-1:0] ifid_inst,
  output logic              ifid_valid,
  output logic [6:0]        ifid_opcode,
  output logic              fetch_fault,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic            load, flush;
  logic            misal;

  assign misal = |redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    load    = 1'b0;
    flush   = 1'b0;
    if (state == RUN) begin
      unique case (1'b1)
        redirect && misal: begin
          state_n = FAULT;
          flush   = 1'b1;
        end
        redirect && !misal: begin
          pc_n  = redirect_pc;
          flush = 1'b1;
        end
        !redirect && stall: ;
        !redirect && !stall: begin
          pc_n = pc + PC_W'(4);
          load = 1'b1;
        end
      endcase
    end else begin
      flush = 1'b1;
    end
  end

  ifid_reg #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .flush   (flush),
    .pc_in   (pc),
    .inst_in (imem_rdata),
    .pc      (ifid_pc),
    .inst    (ifid_inst),
    .valid   (ifid_valid)
  );

  assign imem_addr   = pc;
  assign ifid_opcode = ifid_inst[6:0];
  assign fetch_fault = (state == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (load) begin
      fetch_cnt  <= fetch_cnt + 32'd1;
    end else begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_fetch_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Perf expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic [6:0]  ifid_opcode;
  logic        fetch_fault;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ifid_pc         (ifid_pc),
    .ifid_inst       (ifid_inst),
    .ifid_valid      (ifid_valid),
    .ifid_opcode     (ifid_opcode),
    .fetch_fault     (fetch_fault),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0: op = 7'b0110011;
      3'd1: op = 7'b0010011;
      3'd2: op = 7'b0000011;
      3'd3: op = 7'b0100011;
      3'd4: op = 7'b1100011;
      3'd5: op = 7'b1101111;
      3'd6: op = 7'b1100111;
      default: op = 7'b0010111;
    endcase
    return {a, 16'hC0DE, op};
  endfunction

  assign imem_rdata = word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_addr !== 9'd0 || ifid_valid !== 1'b0 || ifid_inst !== NOP ||
        ifid_pc !== 9'd0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: addr=%h v=%b inst=%h pc=%h flt=%b want 0/0/%h/0/0",
               imem_addr, ifid_valid, ifid_inst, ifid_pc, fetch_fault, NOP);
    end
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: fetch=%0d bubble=%0d want 0/0",
               perf_fetch_cnt, perf_bubble_cnt);
    end
  endtask

  task automatic test_free_run();
    logic [8:0]  exp_pc;
    logic [31:0] exp_w;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_pc = 9'(4 * (k - 1));
      exp_w  = word(exp_pc);
      checks++;
      if (ifid_pc !== exp_pc || ifid_valid !== 1'b1 || ifid_inst !== exp_w ||
          ifid_opcode !== exp_w[6:0] || imem_addr !== 9'(4 * k)) begin
        errors++;
        $display("FAIL free_run%0d: pc=%h v=%b inst=%h op=%h addr=%h want %h/1/%h/%h/%h",
                 k, ifid_pc, ifid_valid, ifid_inst, ifid_opcode, imem_addr,
                 exp_pc, exp_w, exp_w[6:0], 9'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (imem_addr !== 9'd8 || ifid_pc !== 9'd4 || ifid_valid !== 1'b1 ||
          ifid_inst !== word(9'd4)) begin
        errors++;
        $display("FAIL stall_hold%0d: addr=%h pc=%h v=%b inst=%h want 008/004/1/%h",
                 k, imem_addr, ifid_pc, ifid_valid, ifid_inst, word(9'd4));
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (ifid_pc !== 9'd8 || ifid_valid !== 1'b1 || ifid_inst !== word(9'd8) ||
        imem_addr !== 9'd12) begin
      errors++;
      $display("FAIL stall_resume: pc=%h v=%b inst=%h addr=%h want 008/1/%h/00c",
               ifid_pc, ifid_valid, ifid_inst, imem_addr, word(9'd8));
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1;
    redirect_pc = 9'h040;
    stall = 1'b1;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    checks++;
    if (imem_addr !== 9'h040 || ifid_valid !== 1'b0 || ifid_inst !== NOP ||
        ifid_pc !== 9'd0) begin
      errors++;
      $display("FAIL redirect_bubble: addr=%h v=%b inst=%h pc=%h want 040/0/%h/000",
               imem_addr, ifid_valid, ifid_inst, ifid_pc, NOP);
    end
    step();
    checks++;
    if (ifid_pc !== 9'h040 || ifid_valid !== 1'b1 || ifid_inst !== word(9'h040) ||
        imem_addr !== 9'h044) begin
      errors++;
      $display("FAIL redirect_target: pc=%h v=%b inst=%h addr=%h want 040/1/%h/044",
               ifid_pc, ifid_valid, ifid_inst, imem_addr, word(9'h040));
    end
  endtask

  task automatic test_fault();
    redirect = 1'b1;
    redirect_pc = 9'h042;
    step();
    checks++;
    if (fetch_fault !== 1'b1 || imem_addr !== 9'h044 || ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_entry: flt=%b addr=%h v=%b want 1/044/0",
               fetch_fault, imem_addr, ifid_valid);
    end
    for (int k = 0; k < 10; k++) begin
      redirect = k[0];
      redirect_pc = 9'h080;
      stall = k[1];
      step();
      checks++;
      if (fetch_fault !== 1'b1 || imem_addr !== 9'h044 || ifid_valid !== 1'b0 ||
          ifid_inst !== NOP) begin
        errors++;
        $display("FAIL fault_frozen%0d: flt=%b addr=%h v=%b inst=%h want 1/044/0/%h",
                 k, fetch_fault, imem_addr, ifid_valid, ifid_inst, NOP);
      end
    end
    do_reset();
    checks++;
    if (fetch_fault !== 1'b0 || imem_addr !== 9'd0 || ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset: flt=%b addr=%h v=%b want 0/000/0",
               fetch_fault, imem_addr, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 9'h1FC;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if (imem_addr !== 9'h000 || ifid_pc !== 9'h1FC || ifid_valid !== 1'b1 ||
        ifid_inst !== word(9'h1FC)) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h pc=%h v=%b inst=%h want 000/1fc/1/%h",
               imem_addr, ifid_pc, ifid_valid, ifid_inst, word(9'h1FC));
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_f, exp_b;
`ifdef FETCH_PERF_CNT_EN
    exp_f = 32'd7;
    exp_b = 32'd3;
`else
    exp_f = 32'd0;
    exp_b = 32'd0;
`endif
    do_reset();
    for (int k = 0; k < 10; k++) begin
      stall = (k == 2 || k == 5);
      redirect = (k == 7);
      redirect_pc = 9'h020;
      step();
    end
    stall = 1'b0;
    redirect = 1'b0;
    checks++;
    if (perf_fetch_cnt !== exp_f || perf_bubble_cnt !== exp_b) begin
      errors++;
      $display("FAIL perf_cnt: fetch=%0d bubble=%0d want %0d/%0d",
               perf_fetch_cnt, perf_bubble_cnt, exp_f, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_fault();
    test_wrap();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
